adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 27 ++
 rtl/adder_arbiter_if.sv | 42 ++++
 rtl/adder_arbiter_ripple.sv | 30 +++
 rtl/adder_arbiter_rr.sv | 45 ++++
 rtl/adder_arbiter.sv | 96 +++++++++
 tb/tb_adder_arbiter.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/adder_arbiter_pkg.sv
// ============================================================================
// Module      : adder_arbiter_pkg
// Description : Shared defaults, controller state type and index-width helper
//               for the shared-adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 64;

  // IDLE: result register empty; HOLD: result register holds a result.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Requester index width; at least one bit so a single requester still works.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_if.sv
// ============================================================================
// Module      : adder_arbiter_if
// Description : Request/response bundle between the requesters/consumer and
//               the shared-adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);

  localparam int IDW = idx_w(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_ready;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [WIDTH-1:0]            rsp_result;
  logic                        busy;

  // Requesters and result consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface

`default_nettype wire

// File: rtl/adder_arbiter_ripple.sv
// ============================================================================
// Module      : ripple_adder
// Description : Ripple-carry adder, sum modulo 2^WIDTH (carry-out not kept).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_adder #(
  parameter int WIDTH = 64
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output wire logic [WIDTH-1:0] sum_o
);

  // Carry into each bit; the carry out of the top bit is never formed.
  wire logic [WIDTH-1:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ w_carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Picks the first active
//               request at or above ptr_i, wrapping at N_REQ-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = idx_w(DEF_N_REQ)
) (
  input  wire logic [N_REQ-1:0] req_i,
  input  wire logic [IDW-1:0]   ptr_i,
  input  wire logic             en_i,
  output logic      [N_REQ-1:0] gnt_o,
  output logic      [IDW-1:0]   idx_o,
  output logic                  any_o
);

  // Search N_REQ positions starting at ptr_i; first hit wins.
  always_comb begin
    int  pos;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (en_i && !found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
      end
    end
    any_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module      : adder_arbiter
// Description : N_REQ requesters share one adder. Round-robin grant, one-deep
//               result register with back-to-back throughput.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  adder_arbiter_if.slave bus
);

  localparam int IDW = idx_w(N_REQ);

  state_e           state_q,  state_d;
  logic [IDW-1:0]   ptr_q,    ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   id_q,     id_d;

  logic             w_window;
  logic [N_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any_gnt;
  logic [WIDTH-1:0] w_sum;

  // A new operation may be taken when the result register is empty or is
  // being drained this cycle; grants are suppressed while reset is asserted.
  assign w_window = ((state_q == ST_IDLE) || bus.rsp_ready) && reset_n;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .en_i  (w_window),
    .gnt_o (w_gnt),
    .idx_o (w_gnt_idx),
    .any_o (w_any_gnt)
  );

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i   (bus.req_a[w_gnt_idx]),
    .b_i   (bus.req_b[w_gnt_idx]),
    .sum_o (w_sum)
  );

  assign bus.req_ready  = w_gnt;
  assign bus.rsp_valid  = (state_q == ST_HOLD);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.busy       = (state_q == ST_HOLD) || (|bus.req_valid);

  // Next state: a grant loads a new result; a drain with no grant empties.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    id_d     = id_q;
    if (w_any_gnt) begin
      state_d  = ST_HOLD;
      result_d = w_sum;
      id_d     = w_gnt_idx;
      ptr_d    = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
    end else if ((state_q == ST_HOLD) && bus.rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State, pointer and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      result_q <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      id_q     <= id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed self-checking bench for adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  adder_arbiter_if #(.N_REQ(4), .WIDTH(64)) bus ();

  adder_arbiter #(.N_REQ(4), .WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sampling point, half a cycle away from the active edge.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id, input logic [63:0] res);
    check_val({tag, "_valid"}, 64'(bus.rsp_valid), 64'(v));
    check_val({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    check_val({tag, "_result"}, bus.rsp_result, res);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 64'd0;
      bus.req_b[i] = 64'd0;
    end

    // Reset held with all requests active.
    tick();
    tick();
    mid();
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_rsp("rst", 1'b0, 2'd0, 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd1);

    // Release: round-robin 0,1,2,3,0 with consumer always ready.
    tick();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 64'(100 * (i + 1));
      bus.req_b[i] = 64'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      mid();
      check_val("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) check_rsp("rr_rsp", 1'b1, 2'((k - 1) % 4), 64'(101 * (((k - 1) % 4) + 1)));
      tick();
    end
    bus.req_valid = 4'b0000;
    mid();
    check_rsp("rr_last", 1'b1, 2'd0, 64'd101);
    tick();
    mid();
    check_val("drain_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("drain_busy", 64'(bus.busy), 64'd0);

    // Single operation from requester 2 (ptr now 1).
    tick();
    bus.req_valid = 4'b0100;
    bus.req_a[2]  = 64'd10;
    bus.req_b[2]  = 64'd20;
    bus.rsp_ready = 1'b0;
    mid();
    check_val("single_grant", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = 4'b0000;
    mid();
    check_rsp("single_rsp", 1'b1, 2'd2, 64'd30);

    // Backpressure: five stalled cycles with requester 1 waiting.
    bus.req_valid = 4'b0010;
    bus.req_a[1]  = 64'd7;
    bus.req_b[1]  = 64'd8;
    for (int k = 0; k < 5; k++) begin
      mid();
      check_val("bp_ready", 64'(bus.req_ready), 64'd0);
      check_rsp("bp_hold", 1'b1, 2'd2, 64'd30);
      tick();
    end
    bus.rsp_ready = 1'b1;
    mid();
    check_val("bp_grant", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    mid();
    check_rsp("bp_rsp", 1'b1, 2'd1, 64'd15);

    // Wrap-around sums (ptr now 2).
    tick();
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_b[0]  = 64'd1;
    bus.rsp_ready = 1'b1;
    mid();
    check_val("wrap1_grant", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = 4'b1000;
    bus.req_a[3]  = 64'h8000_0000_0000_0000;
    bus.req_b[3]  = 64'h8000_0000_0000_0000;
    mid();
    check_rsp("wrap1_rsp", 1'b1, 2'd0, 64'd0);
    check_val("wrap2_grant", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    mid();
    check_rsp("wrap2_rsp", 1'b1, 2'd3, 64'd0);

    // Leave a result pending and move ptr to 3 before the reset pulse.
    tick();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    mid();
    check_val("pre_rst_grant", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    mid();
    check_rsp("pre_rst_rsp", 1'b1, 2'd2, 64'd30);

    // Reset pulse with a would-be grant present.
    tick();
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    mid();
    check_val("rst_pulse_ready", 64'(bus.req_ready), 64'd0);
    tick();
    reset_n       = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    mid();
    check_rsp("post_rst", 1'b0, 2'd0, 64'd0);
    tick();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    mid();
    check_val("post_rst_ptr", 64'(bus.req_ready), 64'b0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
